// File: rtl/inst_pkg.sv
// Shared definitions for the instruction issue engine.
// Holds the instruction field widths and bit positions, the default
// reserved opcode, the issue FSM state type and the field packing helper.
package inst_pkg;

  localparam int OPC_W  = 2;
  localparam int REG_W  = 5;
  localparam int ALU_W  = 3;
  localparam int INST_W = 20;
  localparam int DATA_W = 32;

  // LSB position of each field inside the 20-bit instruction word
  localparam int OPC_LSB = 18;
  localparam int RD_LSB  = 13;
  localparam int ALU_LSB = 10;
  localparam int RS1_LSB = 5;
  localparam int RS2_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_RSVD_DFLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // {opc, rd, alu, rs1, rs2}, MSB first; fields are placed, never combined
  function automatic logic [INST_W-1:0] pack_inst(
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] rd,
    input logic [ALU_W-1:0] alu,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    logic [INST_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = opc;
    w[RD_LSB  +: REG_W] = rd;
    w[ALU_LSB +: ALU_W] = alu;
    w[RS1_LSB +: REG_W] = rs1;
    w[RS2_LSB +: REG_W] = rs2;
    return w;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding packed instruction words.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers and count)
//   push, wdata  write request and data (ignored when full)
//   pop, rdata   read request and head-of-queue data (ignored when empty)
//   count        exact occupancy, 0..DEPTH
//   full, empty  occupancy flags
module inst_fifo
  import inst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_issuer.sv
// Clocked issue engine for the Inst datapath.
// Packs incoming field bundles into 20-bit words, queues them, drives each
// word on instruccion for SETTLE cycles, then returns ALU_Result with a
// one-cycle res_valid pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | nothing in flight; instruccion keeps its last value
//   HOLD    | instruccion stable, settle down-counter running
//   CAPTURE | result pulse cycle; pops the next word if one is queued
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_ready          field bundle handshake
//   in_opc/rd/alu/rs1/rs2       instruction fields
//   instruccion                 packed word driven to Inst
//   ALU_Result                  result returned by Inst
//   res_valid/res_data/res_inst captured result, its word and valid pulse
//   busy, count                 activity flag and FIFO occupancy
//   err_rsvd                    sticky reserved-opcode drop flag
module inst_issuer
  import inst_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               SETTLE   = 2,
  parameter logic [OPC_W-1:0] OPC_RSVD = OPC_RSVD_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPC_W-1:0]       in_opc,
  input  logic [REG_W-1:0]       in_rd,
  input  logic [ALU_W-1:0]       in_alu,
  input  logic [REG_W-1:0]       in_rs1,
  input  logic [REG_W-1:0]       in_rs2,
  output logic [INST_W-1:0]      instruccion,
  input  logic [DATA_W-1:0]      ALU_Result,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  output logic [INST_W-1:0]      res_inst,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_rsvd
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state;
  state_t            state_nx;
  logic [SW-1:0]     settle_cnt;
  logic              accept;
  logic              rsvd;
  logic              push;
  logic              pop;
  logic              capture;
  logic              fifo_full;
  logic              fifo_empty;
  logic [INST_W-1:0] fifo_rdata;

  assign accept   = in_valid && in_ready;
  assign rsvd     = (in_opc == OPC_RSVD);
  assign push     = accept && !rsvd;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pack_inst(in_opc, in_rd, in_alu, in_rs1, in_rs2)),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (settle_cnt == '0) begin
          capture  = 1'b1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = HOLD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The result registers load on the edge that enters CAPTURE, after the word
  // has been held for exactly SETTLE cycles, so res_valid/res_data/res_inst
  // are all presented together during the CAPTURE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      instruccion <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_inst    <= '0;
      err_rsvd    <= 1'b0;
    end else begin
      state     <= state_nx;
      res_valid <= capture;
      if (pop) begin
        instruccion <= fifo_rdata;
        settle_cnt  <= SW'(SETTLE - 1);
      end else if ((state == HOLD) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        res_data <= ALU_Result;
        res_inst <= instruccion;
      end
      if (accept && rsvd) err_rsvd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_issuer.sv
module tb_inst_issuer;
  localparam int DEPTH = 4;
  localparam int ST0   = 2;
  localparam int ST1   = 5;
  localparam int MAXE  = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [1:0]  in_opc    [2];
  logic [4:0]  in_rd     [2];
  logic [2:0]  in_alu    [2];
  logic [4:0]  in_rs1    [2];
  logic [4:0]  in_rs2    [2];
  logic [19:0] instr     [2];
  logic [31:0] alu_res   [2];
  logic        res_valid [2];
  logic [31:0] res_data  [2];
  logic [19:0] res_inst  [2];
  logic        busy      [2];
  logic [2:0]  count     [2];
  logic        err_rsvd  [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int st [2] = '{ST0, ST1};

  // model: every accepted legal word with its write edge and issue edge
  logic [19:0] m_word [2][MAXE];
  int          m_wr   [2][MAXE];
  int          m_is   [2][MAXE];
  int          m_n    [2] = '{0, 0};
  bit          m_err  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  // stand-in for the Inst datapath: result depends on rd, rs1, rs2
  function automatic logic [31:0] alu_fn(input logic [19:0] w);
    return 32'(w[17:13]) + 32'(w[4:0]) + (32'(w[9:5]) << 8);
  endfunction

  assign alu_res[0] = alu_fn(instr[0]);
  assign alu_res[1] = alu_fn(instr[1]);

  inst_issuer #(.DEPTH(DEPTH), .SETTLE(ST0), .OPC_RSVD(2'b11)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_opc(in_opc[0]), .in_rd(in_rd[0]), .in_alu(in_alu[0]), .in_rs1(in_rs1[0]),
    .in_rs2(in_rs2[0]), .instruccion(instr[0]), .ALU_Result(alu_res[0]),
    .res_valid(res_valid[0]), .res_data(res_data[0]), .res_inst(res_inst[0]),
    .busy(busy[0]), .count(count[0]), .err_rsvd(err_rsvd[0]));

  inst_issuer #(.DEPTH(DEPTH), .SETTLE(ST1), .OPC_RSVD(2'b11)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_opc(in_opc[1]), .in_rd(in_rd[1]), .in_alu(in_alu[1]), .in_rs1(in_rs1[1]),
    .in_rs2(in_rs2[1]), .instruccion(instr[1]), .ALU_Result(alu_res[1]),
    .res_valid(res_valid[1]), .res_data(res_data[1]), .res_inst(res_inst[1]),
    .busy(busy[1]), .count(count[1]), .err_rsvd(err_rsvd[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count(input int i, input int e);
    int c = 0;
    for (int k = 0; k < m_n[i]; k++) begin
      if (m_wr[i][k] <= e) c++;
      if (m_is[i][k] <= e) c--;
    end
    return c;
  endfunction

  // model update at each active edge: a word issues one edge after it is
  // written, but never sooner than SETTLE+1 edges after the previous issue
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && (m_count(i, cyc - 1) < DEPTH)) begin
          if (in_opc[i] == 2'b11) begin
            m_err[i] = 1'b1;
          end else begin
            automatic int n = m_n[i];
            automatic int t = cyc + 1;
            if (n > 0 && (m_is[i][n-1] + st[i] + 1) > t) t = m_is[i][n-1] + st[i] + 1;
            m_word[i][n] = {in_opc[i], in_rd[i], in_alu[i], in_rs1[i], in_rs2[i]};
            m_wr[i][n]   = cyc;
            m_is[i][n]   = t;
            m_n[i]       = n + 1;
          end
        end
      end
    end
  end

  // compare every output of both instances on every falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic int          e   = cyc;
        automatic int          c   = m_count(i, e);
        automatic logic [19:0] ei  = '0;
        automatic logic [19:0] eri = '0;
        automatic logic [31:0] erd = '0;
        automatic logic        ev  = 1'b0;
        automatic logic        eb  = (c > 0);
        for (int k = 0; k < m_n[i]; k++) begin
          if (m_is[i][k] <= e) ei = m_word[i][k];
          if (m_is[i][k] + st[i] <= e) begin
            eri = m_word[i][k];
            erd = alu_fn(m_word[i][k]);
          end
          if (m_is[i][k] + st[i] == e) ev = 1'b1;
          if (m_is[i][k] <= e && e < m_is[i][k] + st[i] + 1) eb = 1'b1;
        end
        check($sformatf("u%0d.instruccion", i), 32'(instr[i]), 32'(ei));
        check($sformatf("u%0d.res_valid", i), 32'(res_valid[i]), 32'(ev));
        check($sformatf("u%0d.res_data", i), res_data[i], erd);
        check($sformatf("u%0d.res_inst", i), 32'(res_inst[i]), 32'(eri));
        check($sformatf("u%0d.count", i), 32'(count[i]), 32'(c));
        check($sformatf("u%0d.in_ready", i), 32'(in_ready[i]), 32'(c < DEPTH));
        check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(eb));
        check($sformatf("u%0d.err_rsvd", i), 32'(err_rsvd[i]), 32'(m_err[i]));
      end
    end
  end

  // called at a falling edge; returns at the falling edge after the transfer
  task automatic push(input int i, input logic [1:0] opc, input logic [4:0] rd,
                      input logic [2:0] alu, input logic [4:0] rs1, input logic [4:0] rs2);
    int g = 0;
    in_valid[i] = 1'b1;
    in_opc[i] = opc; in_rd[i] = rd; in_alu[i] = alu; in_rs1[i] = rs1; in_rs2[i] = rs2;
    while (!in_ready[i] && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", 32'(in_ready[i]), 32'd1);
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_res(input int i, output int e);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!res_valid[i] && g < 200);
    check("res_wait", 32'(res_valid[i]), 32'd1);
    e = cyc;
  endtask

  task automatic wait_idle(input int i);
    int g = 0;
    while (busy[i] && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("idle_wait", 32'(busy[i]), 32'd0);
  endtask

  task automatic count_pulses(input int i, input int ncyc, output int p);
    p = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (res_valid[i]) p++;
    end
  endtask

  initial begin
    int w_edge, r_edge, p;
    int r_e [5];
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_opc[i] = '0; in_rd[i] = '0;
      in_alu[i] = '0; in_rs1[i] = '0; in_rs2[i] = '0;
    end

    // reset values
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_instr", 32'(instr[i]), 32'd0);
      check("rst_valid", 32'(res_valid[i]), 32'd0);
      check("rst_data", res_data[i], 32'd0);
      check("rst_inst", 32'(res_inst[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_count", 32'(count[i]), 32'd0);
      check("rst_err", 32'(err_rsvd[i]), 32'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // single issue
    push(0, 2'b01, 5'd4, 3'd2, 5'd0, 5'd3);
    w_edge = cyc;
    @(negedge clk);
    check("t1_instr", 32'(instr[0]), 32'(20'b01_00100_010_00000_00011));
    wait_res(0, r_edge);
    check("t1_latency", 32'(r_edge - w_edge), 32'd3);
    check("t1_data", res_data[0], 32'h0000_0007);
    check("t1_inst", 32'(res_inst[0]), 32'(20'b01_00100_010_00000_00011));
    wait_idle(0);

    // burst of five into the slow instance
    for (int p5 = 0; p5 < 5; p5++)
      push(1, 2'(p5 % 3), 5'(p5 + 1), 3'(p5), 5'(p5 + 7), 5'(2 * p5));
    check("t2_count_full", 32'(count[1]), 32'd4);
    check("t2_ready_low", 32'(in_ready[1]), 32'd0);
    for (int k = 0; k < 5; k++) wait_res(1, r_e[k]);
    for (int k = 1; k < 5; k++) check("t2_spacing", 32'(r_e[k] - r_e[k-1]), 32'd6);
    wait_idle(1);

    // reserved opcode between two legal pushes
    push(0, 2'b10, 5'd1, 3'd1, 5'd1, 5'd1);
    push(0, 2'b11, 5'd31, 3'd7, 5'd31, 5'd31);
    push(0, 2'b00, 5'd2, 3'd2, 5'd2, 5'd2);
    count_pulses(0, 30, p);
    check("t3_results", 32'(p), 32'd2);
    check("t3_err", 32'(err_rsvd[0]), 32'd1);
    wait_idle(0);

    // steady state at count 2 with push and pop on the same edge
    for (int k = 0; k < 3; k++) push(0, 2'(k % 3), 5'(k + 10), 3'(k), 5'(k), 5'(31 - k));
    @(negedge clk);
    for (int k = 3; k < 8; k++) begin
      push(0, 2'(k % 3), 5'(k + 10), 3'(k), 5'(k), 5'(31 - k));
      check("t4_count_hold", 32'(count[0]), 32'd2);
      @(negedge clk);
      @(negedge clk);
    end
    wait_idle(0);

    // reset one cycle into HOLD
    push(0, 2'b10, 5'd9, 3'd1, 5'd2, 5'd6);
    @(negedge clk);
    check("t5_busy_pre", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0;
      m_err[i] = 1'b0;
    end
    #1;
    check("t5_instr", 32'(instr[0]), 32'd0);
    check("t5_valid", 32'(res_valid[0]), 32'd0);
    check("t5_data", res_data[0], 32'd0);
    check("t5_inst", 32'(res_inst[0]), 32'd0);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_count", 32'(count[0]), 32'd0);
    check("t5_err", 32'(err_rsvd[0]), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    count_pulses(0, 6, p);
    check("t5_no_result", 32'(p), 32'd0);
    push(0, 2'b10, 5'd1, 3'd3, 5'd4, 5'd5);
    wait_res(0, r_edge);
    check("t5_new_data", res_data[0], 32'd1030);

    // idle hold
    count_pulses(0, 20, p);
    check("t6_no_pulse", 32'(p), 32'd0);
    check("t6_instr", 32'(instr[0]), 32'(20'b10_00001_011_00100_00101));
    check("t6_busy", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
